// File: rtl/lamp_driver_monitor.sv
// Lamp driver for the traffic-controller code stream: decodes codes into per-direction
// lamp drives, enforces all-red clearance before greens, and latches safety faults.
module lamp_driver_monitor #(
    parameter int CLEAR_CYCLES = 3,
    parameter int MAX_GREEN    = 8,
    parameter int FLASH_HALF   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] light_code,
    input  logic       clear_fault,
    output logic [3:0] lamp_red,
    output logic [3:0] lamp_yel,
    output logic [3:0] lamp_grn,
    output logic       clearing,
    output logic       fault,
    output logic [1:0] fault_code
);
    localparam int CW = $clog2(CLEAR_CYCLES + 1);
    localparam int WW = $clog2(MAX_GREEN + 2);
    localparam int FW = $clog2(2 * FLASH_HALF);
    localparam logic [CW-1:0] CLR_MAX = CW'(CLEAR_CYCLES);
    localparam logic [WW-1:0] WD_MAX  = WW'(MAX_GREEN);
    localparam logic [WW-1:0] WD_SAT  = WW'(MAX_GREEN + 1);
    localparam logic [FW-1:0] FH      = FW'(FLASH_HALF);
    localparam logic [FW-1:0] FLAST   = FW'(2 * FLASH_HALF - 1);

    typedef enum logic [1:0] {S_RED, S_GRN, S_YEL, S_FLT} disp_t;

    function automatic logic is_grn(input logic [3:0] c);
        return c inside {4'd1, 4'd3, 4'd5, 4'd7};
    endfunction

    function automatic logic is_yel(input logic [3:0] c);
        return c inside {4'd2, 4'd4, 4'd6, 4'd8};
    endfunction

    // Both green (2d+1) and yellow (2d+2) map to d via (c-1)>>1.
    function automatic logic [1:0] dir_of(input logic [3:0] c);
        return 2'((c - 4'd1) >> 1);
    endfunction

    logic [3:0]    code_q, prev_q;
    disp_t         disp, disp_nxt;
    logic [1:0]    dir, dir_nxt;
    logic [CW-1:0] clr_cnt, clr_nxt, clr_upd;
    logic [WW-1:0] wd_cnt, wd_prior, wd_nxt;
    logic [FW-1:0] flash_cnt, flash_nxt;
    logic          bad_code, bad_trans, wd_hit;
    logic          fault_nxt, clearing_nxt;
    logic [1:0]    fcode_nxt;
    logic [3:0]    red_nxt, yel_nxt, grn_nxt, onehot;

    always_comb begin
        bad_code  = code_q > 4'd8;
        bad_trans = (is_grn(prev_q) && !((is_grn(code_q) || is_yel(code_q)) &&
                                         dir_of(code_q) == dir_of(prev_q)))
                 || (is_yel(prev_q) && ((is_grn(code_q) && dir_of(code_q) == dir_of(prev_q)) ||
                                        (is_yel(code_q) && dir_of(code_q) != dir_of(prev_q))))
                 || (prev_q == 4'd0 && is_yel(code_q));

        // wd_prior: how many earlier consecutive cycles code_q already held this green.
        wd_prior = (is_grn(code_q) && code_q == prev_q) ? wd_cnt : '0;
        wd_hit   = is_grn(code_q) && wd_prior == WD_MAX;
        if (!is_grn(code_q))      wd_nxt = '0;
        else if (wd_prior == WD_SAT) wd_nxt = wd_prior;
        else                      wd_nxt = wd_prior + WW'(1);

        // Clearance credit including the cycle currently on display.
        case (disp)
            S_YEL:   clr_nxt = '0;
            S_RED:   clr_nxt = (clr_cnt == CLR_MAX) ? clr_cnt : clr_cnt + CW'(1);
            default: clr_nxt = clr_cnt;
        endcase
    end

    always_comb begin
        disp_nxt     = disp;
        dir_nxt      = dir;
        clr_upd      = clr_nxt;
        flash_nxt    = flash_cnt;
        fault_nxt    = fault;
        fcode_nxt    = fault_code;
        clearing_nxt = 1'b0;
        if (disp == S_FLT) begin
            if (clear_fault && code_q == 4'd0) begin
                disp_nxt  = S_RED;
                fault_nxt = 1'b0;
                fcode_nxt = 2'd0;
                clr_upd   = '0;
                flash_nxt = '0;
            end else begin
                flash_nxt = (flash_cnt == FLAST) ? '0 : flash_cnt + FW'(1);
            end
        end else if (bad_code || bad_trans || wd_hit) begin
            disp_nxt  = S_FLT;
            fault_nxt = 1'b1;
            fcode_nxt = bad_code ? 2'd1 : (bad_trans ? 2'd2 : 2'd3);
            flash_nxt = '0;
        end else if (code_q == 4'd0) begin
            disp_nxt = S_RED;
        end else if (is_grn(code_q)) begin
            if ((disp == S_GRN && dir == dir_of(code_q)) || clr_nxt == CLR_MAX) begin
                disp_nxt = S_GRN;
                dir_nxt  = dir_of(code_q);
            end else begin
                disp_nxt     = S_RED;
                clearing_nxt = 1'b1;
            end
        end else if ((disp == S_GRN || disp == S_YEL) && dir == dir_of(code_q)) begin
            disp_nxt = S_YEL;
        end else begin
            disp_nxt = S_RED;
        end
    end

    always_comb begin
        onehot  = 4'b0001 << dir_nxt;
        red_nxt = 4'b1111;
        yel_nxt = 4'b0000;
        grn_nxt = 4'b0000;
        case (disp_nxt)
            S_GRN: begin
                red_nxt = ~onehot;
                grn_nxt = onehot;
            end
            S_YEL: begin
                red_nxt = ~onehot;
                yel_nxt = onehot;
            end
            S_FLT:   red_nxt = (flash_nxt < FH) ? 4'b1111 : 4'b0000;
            default: red_nxt = 4'b1111;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q     <= 4'd0;
            prev_q     <= 4'd0;
            disp       <= S_RED;
            dir        <= 2'd0;
            clr_cnt    <= CLR_MAX;
            wd_cnt     <= '0;
            flash_cnt  <= '0;
            lamp_red   <= 4'b1111;
            lamp_yel   <= 4'b0000;
            lamp_grn   <= 4'b0000;
            clearing   <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'd0;
        end else begin
            code_q     <= light_code;
            prev_q     <= code_q;
            disp       <= disp_nxt;
            dir        <= dir_nxt;
            clr_cnt    <= clr_upd;
            wd_cnt     <= wd_nxt;
            flash_cnt  <= flash_nxt;
            lamp_red   <= red_nxt;
            lamp_yel   <= yel_nxt;
            lamp_grn   <= grn_nxt;
            clearing   <= clearing_nxt;
            fault      <= fault_nxt;
            fault_code <= fcode_nxt;
        end
    end
endmodule
